// File: rtl/shift_pkg.sv
// Shared types and widths for the shift arbiter and its shifter datapath.
package shift_pkg;

    localparam int SHIFT_W = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRA = 2'd1,
        ROR = 2'd2,
        RSV = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-requester round-robin grant; prio names the port that wins a tie.
module rr_arb2
    import shift_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // One-hot grant; a lone requester always wins regardless of prio.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/shifter.sv
// Combinational 16-bit shifter: logical left, arithmetic right, rotate right.
module shifter
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  shift_mode_t        in_mode,
    output logic [SHIFT_W-1:0] out_data
);

    logic [SHAMT_W:0] rot_back_s;

    assign rot_back_s = 5'd16 - {1'b0, in_amt};

    // Mode select; shifting a 16-bit value by 16 yields zero, so amt=0 rotates cleanly.
    always_comb begin
        out_data = in_data;
        case (in_mode)
            SLL:     out_data = in_data << in_amt;
            SRA:     out_data = $signed(in_data) >>> in_amt;
            ROR:     out_data = (in_data >> in_amt) | (in_data << rot_back_s);
            default: out_data = in_data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter between two requesters: round-robin accept, registered
// operands, one execute cycle, then a held response until the winner accepts it.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int AMT_W      = 4,
    parameter int RESET_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [AMT_W-1:0]  req_amt1,
    input  logic [1:0]        req_mode0,
    input  logic [1:0]        req_mode1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam logic PRIO_INIT = (RESET_PRIO != 0) ? 1'b1 : 1'b0;

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              prio_q, prio_d;
    logic [DATA_W-1:0] op_data_q, op_data_d;
    logic [AMT_W-1:0]  op_amt_q, op_amt_d;
    shift_mode_t       op_mode_q, op_mode_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [1:0]        gnt_s;
    logic [1:0]        req_ready_s;
    logic [DATA_W-1:0] shift_out_s;

    rr_arb2 u_arb (
        .req  (req_valid),
        .prio (prio_q),
        .gnt  (gnt_s)
    );

    shifter u_shifter (
        .in_data  (op_data_q),
        .in_amt   (op_amt_q),
        .in_mode  (op_mode_q),
        .out_data (shift_out_s)
    );

    // Next-state, operand capture and response logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        op_data_d   = op_data_q;
        op_amt_d    = op_amt_q;
        op_mode_d   = op_mode_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_s = 2'b00;
        case (state_q)
            IDLE: begin
                req_ready_s = gnt_s;
                if ((req_valid & gnt_s) != 2'b00) begin
                    grant_d   = gnt_s[1];
                    op_data_d = gnt_s[1] ? req_data1 : req_data0;
                    op_amt_d  = gnt_s[1] ? req_amt1  : req_amt0;
                    op_mode_d = shift_mode_t'(gnt_s[1] ? req_mode1 : req_mode0);
                    state_d   = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // Reserved mode bypasses the shifter entirely.
                rsp_data_d  = (op_mode_q == RSV) ? op_data_q : shift_out_s;
                rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = 2'b00;
                    prio_d      = ~grant_q;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            prio_q      <= PRIO_INIT;
            op_data_q   <= {DATA_W{1'b0}};
            op_amt_q    <= {AMT_W{1'b0}};
            op_mode_q   <= SLL;
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            op_data_q   <= op_data_d;
            op_amt_q    <= op_amt_d;
            op_mode_q   <= op_mode_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized bench for shift_arbiter with a behavioural shift/arbitration model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_data0, req_data1, rsp_data;
    logic [3:0]  req_amt0, req_amt1;
    logic [1:0]  req_mode0, req_mode1;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_arbiter #(.DATA_W(16), .AMT_W(4), .RESET_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_amt0(req_amt0), .req_amt1(req_amt1),
        .req_mode0(req_mode0), .req_mode1(req_mode1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int a, input int m);
        int unsigned x;
        int          s;
        int unsigned r;
        x = d;
        s = $signed(d);
        case (m)
            0:       r = (x << a) % 65536;
            1:       r = (s >>> a) & 32'hFFFF;
            2:       r = ((x >> a) | (x << (16 - a))) % 65536;
            default: r = x;
        endcase
        return r[15:0];
    endfunction

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_port(input int p, input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        if (p == 0) begin
            req_data0 = d; req_amt0 = a; req_mode0 = m;
        end else begin
            req_data1 = d; req_amt1 = a; req_mode1 = m;
        end
    endtask

    // Issues one request on port p with rsp_ready high and reports what it observed.
    task automatic run_op(input int p, input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                          output logic rdy0, output logic [15:0] res, output int edges, output int busy_n);
        @(posedge clk); #1;
        set_port(p, d, a, m);
        req_valid = (p == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        rdy0 = req_ready[p];
        busy_n = 0;
        res = 16'hxxxx;
        @(posedge clk); #1;
        req_valid = 2'b00;
        edges = 1;
        while (edges < 10) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (rsp_valid[p]) begin
                res = rsp_data;
                break;
            end
            @(posedge clk);
            edges++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        n_checks++; if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        n_checks++; if (rsp_data !== 16'h0000) begin n_errors++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_port0();
        logic r; logic [15:0] res; int e, b;
        run_op(0, 16'h3333, 4'd4, 2'd0, r, res, e, b);
        n_checks++; if (r !== 1'b1) begin n_errors++; $display("FAIL p0_ready_same_cycle got=%b exp=1", r); end
        n_checks++; if (res !== 16'h3330) begin n_errors++; $display("FAIL p0_sll got=%h exp=3330", res); end
        n_checks++; if (e != 2) begin n_errors++; $display("FAIL p0_latency got=%0d exp=2", e); end
        n_checks++; if (b != 2) begin n_errors++; $display("FAIL p0_busy_cycles got=%0d exp=2", b); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL p0_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_port1();
        logic r; logic [15:0] res; int e, b;
        run_op(1, 16'h8001, 4'd1, 2'd1, r, res, e, b);
        n_checks++; if (res !== 16'hC000) begin n_errors++; $display("FAIL p1_sra got=%h exp=c000", res); end
        run_op(1, 16'h3333, 4'd5, 2'd2, r, res, e, b);
        n_checks++; if (res !== 16'h9999) begin n_errors++; $display("FAIL p1_ror got=%h exp=9999", res); end
        run_op(1, 16'h1234, 4'd7, 2'd3, r, res, e, b);
        n_checks++; if (res !== 16'h1234) begin n_errors++; $display("FAIL p1_bypass got=%h exp=1234", res); end
        for (int m = 0; m < 3; m++) begin
            run_op(1, 16'hA5C3, 4'd0, m[1:0], r, res, e, b);
            n_checks++; if (res !== 16'hA5C3) begin n_errors++; $display("FAIL amt0_mode%0d got=%h exp=a5c3", m, res); end
        end
    endtask

    task automatic test_both_valid();
        do_reset();
        @(posedge clk); #1;
        set_port(0, 16'h0001, 4'd15, 2'd0);
        set_port(1, 16'h0001, 4'd1, 2'd0);
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL both_first_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b10;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL both_exec_ready got=%b exp=00", req_ready); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h8000) begin n_errors++; $display("FAIL both_p0_rsp got=%b/%h exp=01/8000", rsp_valid, rsp_data); end
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL both_resp_ready got=%b exp=00", req_ready); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL both_second_grant got=%b exp=10", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 16'h0002) begin n_errors++; $display("FAIL both_p1_rsp got=%b/%h exp=10/0002", rsp_valid, rsp_data); end
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL both_rr_back_to_p0 got=%b exp=01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        set_port(0, 16'h00F0, 4'd4, 2'd0);
        req_valid = 2'b01;
        @(posedge clk); #1 req_valid = 2'b10;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_port(1, 16'($urandom), 4'($urandom), 2'($urandom));
            n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h0F00 || req_ready !== 2'b00)
                begin n_errors++; $display("FAIL bp_hold_%0d got=%b/%h/%b exp=01/0f00/00", i, rsp_valid, rsp_data, req_ready); end
            @(posedge clk);
        end
        #1 req_valid = 2'b00; rsp_ready = 2'b11;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b01) begin n_errors++; $display("FAIL bp_last got=%b exp=01", rsp_valid); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_errors++; $display("FAIL bp_release got=%b/%b exp=00/0", rsp_valid, busy); end
    endtask

    // Resets while in flight (depth 1 = execute, 2 = response held) and checks nothing leaks out.
    task automatic test_reset_mid(input int depth);
        logic r; logic [15:0] res; int e, b;
        run_op(0, 16'h0011, 4'd1, 2'd0, r, res, e, b);
        rsp_ready = 2'b00;
        set_port(1, 16'h0F0F, 4'd3, 2'd2);
        req_valid = 2'b10;
        @(posedge clk); #1 req_valid = 2'b00;
        if (depth == 2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid%0d_outputs got=%b/%b exp=00/0", depth, rsp_valid, busy); end
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rst_mid%0d_prio got=%b exp=01", depth, req_ready); end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid%0d_stale_%0d got=%b/%b exp=00/0", depth, i, rsp_valid, busy); end
        end
    endtask

    task automatic test_random();
        int          stage;      // 0 idle, 1 executing, 2 response offered
        int          owner;
        int          prio;
        logic [15:0] m_result;
        logic [1:0]  exp_ready;
        int          issued[2], done[2], foreign[2];
        int          cycles;
        issued = '{0, 0}; done = '{0, 0}; foreign = '{0, 0};
        stage = 0; owner = 0; prio = 0; m_result = 16'h0000;
        do_reset();
        cycles = 0;
        while ((done[0] + done[1]) < 1000 && cycles < 20000) begin
            @(negedge clk);
            if (stage == 0) begin
                if (req_valid == 2'b11) exp_ready = (prio == 1) ? 2'b10 : 2'b01;
                else exp_ready = req_valid;
            end else begin
                exp_ready = 2'b00;
            end
            n_checks++; if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cycles, req_ready, exp_ready); end
            n_checks++; if (busy !== (stage != 0)) begin n_errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cycles, busy, stage != 0); end
            n_checks++; if (rsp_valid !== ((stage == 2) ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00))
                begin n_errors++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b stage=%0d owner=%0d", cycles, rsp_valid, stage, owner); end
            if (stage == 2) begin
                n_checks++; if (rsp_data !== m_result) begin n_errors++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", cycles, rsp_data, m_result); end
            end
            @(posedge clk);
            if (stage == 2) begin
                if (rsp_ready[owner]) begin
                    done[owner]++;
                    prio = 1 - owner;
                    stage = 0;
                end
            end else if (stage == 1) begin
                stage = 2;
            end else if (exp_ready != 2'b00) begin
                owner = exp_ready[1] ? 1 : 0;
                m_result = (owner == 1) ? ref_shift(req_data1, req_amt1, req_mode1)
                                        : ref_shift(req_data0, req_amt0, req_mode0);
                issued[owner]++;
                foreign[owner] = 0;
                if (req_valid[1 - owner]) begin
                    foreign[1 - owner]++;
                    n_checks++; if (foreign[1 - owner] > 1) begin n_errors++; $display("FAIL rnd_fairness port=%0d waited=%0d exp<=1", 1 - owner, foreign[1 - owner]); end
                end
                stage = 1;
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                if (stage != 0 && owner == p && issued[p] > done[p]) req_valid[p] = 1'b0;
                else if (!req_valid[p] && ($urandom_range(0, 2) == 0)) req_valid[p] = 1'b1;
                if (req_valid[p]) set_port(p, 16'($urandom), 4'($urandom), 2'($urandom));
            end
            rsp_ready = 2'($urandom);
            cycles++;
        end
        req_valid = 2'b00;
        n_checks++; if ((done[0] + done[1]) < 1000) begin n_errors++; $display("FAIL rnd_timeout done=%0d exp=1000", done[0] + done[1]); end
        for (int p = 0; p < 2; p++) begin
            n_checks++; if (issued[p] != done[p] || done[p] == 0)
                begin n_errors++; $display("FAIL rnd_count port=%0d issued=%0d done=%0d", p, issued[p], done[p]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_data0 = 16'h0000; req_data1 = 16'h0000;
        req_amt0 = 4'd0; req_amt1 = 4'd0;
        req_mode0 = 2'd0; req_mode1 = 2'd0;
        test_reset();
        test_port0();
        test_port1();
        test_both_valid();
        test_backpressure();
        test_reset_mid(1);
        test_reset_mid(2);
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
